mem_copy_ctrl: RTL

Initiator that drives the single-port 16-bit data memory interface: 16-bit address, write data, write enable, read enable, and a combinational read-data return. On a start command it copies LEN words from SRC to DST, one read cycle and one write cycle per word. It sits between the control unit and the data memory. It provides block-move and initialisation support without CPU load/store loops.

---
 rtl/mem_copy_pkg.sv | 8 +
 rtl/mem_copy_addr_gen.sv | 41 ++++
 rtl/mem_copy_ctrl.sv | 74 +++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared types and defaults for the memory copy controller.
package mem_copy_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 8;
  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/mem_copy_addr_gen.sv
// mem_copy_addr_gen: source/destination pointers and remaining-word count.
//   load   : capture src_in/dst_in/len_in
//   step   : advance both pointers (modulo 2^ADDR_W) and decrement the count
//   last   : the count is exactly one, so the current word is the final one
module mem_copy_addr_gen import mem_copy_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] cur_src,
  output logic [ADDR_W-1:0] cur_dst,
  output logic              last
);
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  always_comb begin
    src_d    = load ? src_in : step ? src_q + ADDR_W'(1) : src_q;
    dst_d    = load ? dst_in : step ? dst_q + ADDR_W'(1) : dst_q;
    remain_d = load ? len_in : step ? remain_q - LEN_W'(1) : remain_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      remain_q <= remain_d;
    end
  end
  assign cur_src = src_q;
  assign cur_dst = dst_q;
  assign last    = remain_q == LEN_W'(1);
endmodule

// File: rtl/mem_copy_ctrl.sv
// mem_copy_ctrl: copies len words from src_addr to dst_addr, one read and one write cycle per word.
//   clk, rst (sync, active-low); start/src_addr/dst_addr/len command; busy/done status;
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata single-port memory (combinational read).
//   MEM_COPY_CHECKSUM_EN adds output checksum: sum of the words written since the last start.
module mem_copy_ctrl import mem_copy_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] cur_src, cur_dst;
  logic              load, step, last, accept;
  mem_copy_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk(clk), .rst(rst), .load(load), .step(step),
    .src_in(src_addr), .dst_in(dst_addr), .len_in(len),
    .cur_src(cur_src), .cur_dst(cur_dst), .last(last)
  );
  always_comb begin
    accept  = state_q == IDLE && start;
    load    = accept;
    step    = state_q == WRITE;
    buf_d   = state_q == READ ? mem_rdata : buf_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !start ? IDLE : len == '0 ? DONE : READ;
      READ:    state_d = WRITE;
      WRITE:   state_d = last ? DONE : READ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      buf_q   <= DATA_W'(ZERO_WORD);
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign mem_re    = state_q == READ;
  assign mem_we    = state_q == WRITE;
  assign mem_addr  = mem_re ? cur_src : mem_we ? cur_dst : '0;
  assign mem_wdata = mem_we ? buf_q : '0;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;
  always_comb checksum_d = accept ? '0 : mem_we ? checksum_q + buf_q : checksum_q;
  always_ff @(posedge clk) begin
    if (!rst) checksum_q <= '0;
    else checksum_q <= checksum_d;
  end
  assign checksum = checksum_q;
`endif
endmodule
